yuv_upsample_csc: RTL
=====================

YUV_UPSAMPLE_CSC -- requirements
Module: yuv_upsample_csc

Interface
REQ-001 SHALL have parameter DATA_W, default 8: bits per colour component.
REQ-002 SHALL have parameter ROW_PAIRS, default 160: pixel pairs per row, at least 4.
REQ-003 SHALL have parameter ROWS, default 240: rows per frame.
REQ-004 SHALL have port Clock  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port Resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a frame; ignored unless the FSM is in IDLE.
REQ-007 SHALL have port mode_444  input  1  0 = 4:2:0 (interpolate odd U/V), 1 = 4:4:4 (use supplied odd U/V); sampled on start.
REQ-008 SHALL have port s_valid  input  1  input pair valid.
REQ-009 SHALL have port s_ready  output  1  block accepts an input pair.
REQ-010 SHALL have port s_data  input  6*DATA_W  {Y_even, Y_odd, U_even, V_even, U_odd, V_odd}, MSB first.
REQ-011 SHALL have port m_valid  output  1  output pair valid.
REQ-012 SHALL have port m_ready  input  1  downstream accepts the output pair.
REQ-013 SHALL have port m_data  output  6*DATA_W  {R0, G0, B0, R1, G1, B1}, MSB first.
REQ-014 SHALL have port m_eol  output  1  qualifies m_valid; marks the last pair of a row.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the last pair of the frame is transferred.

Function
REQ-016 SHALL transfer on s_valid&&s_ready and m_valid&&m_ready only; m_data and m_eol SHALL stay stable while m_valid=1 and m_ready=0.
REQ-017 SHALL run FSM IDLE -> PRIME (start) -> STREAM (after 3 pairs accepted) -> FLUSH (last row pair accepted) -> ROW_END (3 flush pairs emitted) -> PRIME (rows remain) or DONE -> IDLE.
REQ-018 SHALL assert s_ready only in PRIME/STREAM while the output register is empty or being transferred that cycle.
REQ-019 SHALL hold a 6-entry U and V shift window plus a 4-deep Y-pair delay; output pair m SHALL be produced from window U[m-2..m+3] and Y pair m.
REQ-020 SHALL clamp window indices: index < 0 uses sample 0 of the row, index > ROW_PAIRS-1 uses sample ROW_PAIRS-1; FLUSH replicates the last sample without accepting input.
REQ-021 SHALL use U_even[m] directly for the even pixel; in 4:2:0 the odd U SHALL be (21U[m-2] - 52U[m-1] + 159U[m] + 159U[m+1] - 52U[m+2] + 21U[m+3] + 128) >>> 8 signed, clipped to 0..2^DATA_W-1; V identically.
REQ-022 SHALL in 4:4:4 use delayed U_odd/V_odd unfiltered, with the same 3-pair alignment delay.
REQ-023 SHALL compute, with y = Y - 16*2^(DATA_W-8), u = U - 2^(DATA_W-1), v = V - 2^(DATA_W-1), signed 32+2*(DATA_W-8) bit products: R = (76284y + 104595v) >>> 16, G = (76284y - 25624u - 53281v) >>> 16, B = (76284y + 132251u) >>> 16.
REQ-024 SHALL clip each of R, G and B to 0..2^DATA_W-1.
REQ-025 SHALL, with m_ready held at 1, assert m_valid 2 cycles after the acceptance or flush step that completes pair m's window.
REQ-026 SHALL assert m_eol on pair ROW_PAIRS-1 and reset the window and row counters at each row boundary, so no samples mix between rows.
REQ-027 SHALL ignore start while not in IDLE.

Reset
REQ-028 SHALL, while Resetn=0, force s_ready=0, m_valid=0, m_data=0, m_eol=0 and done=0, clear all counters, windows and delays, and set the FSM to IDLE.
REQ-029 SHALL, on Resetn asserted mid-frame, discard the frame; operation SHALL resume only on a new start.

Verification
REQ-030 SHALL cover: grey frame Y=U=V=128, mode_444=0 -> every component 130; done once after ROWS*ROW_PAIRS transfers.
REQ-031 SHALL cover: Y=255, U=V=255 -> R=255, G=125, B=255; Y=0, U=V=128 -> all components 0.
REQ-032 SHALL cover: row with U[0]=0, all other U=100, mode_444=0 -> pair 0 odd U'=50 (check via B1); last pair uses the replicated edge sample.
REQ-033 SHALL cover: mode_444=1 with U_odd != U_even -> odd pixel uses U_odd unfiltered.
REQ-034 SHALL cover: m_ready low 5 cycles mid-row -> m_data stable, s_ready=0 once full, no pair lost or duplicated; random s_valid/m_ready gaps -> output matches reference model.
REQ-035 SHALL cover: Resetn pulsed mid-row -> all outputs 0 next cycle; a new start gives a correct full frame.

Source files
------------

// File: rtl/yuv_upsample_csc.sv
// Pixel-pair stream converter: chroma upsampling (6-tap or pass-through) then YUV->RGB.
// The window advances on each accepted or flushed pair; two register stages follow it.
module yuv_upsample_csc #(
  parameter int DATA_W    = 8,
  parameter int ROW_PAIRS = 160,
  parameter int ROWS      = 240
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  start,
  input  logic                  mode_444,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [6*DATA_W-1:0]   s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [6*DATA_W-1:0]   m_data,
  output logic                  m_eol,
  output logic                  done
);
  localparam int CW = $clog2(ROW_PAIRS + 1);
  localparam int RW = $clog2(ROWS + 1);
  localparam int FW = DATA_W + 12;
  localparam int PW = 32 + 2 * (DATA_W - 8);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PRIME   = 3'd1;
  localparam logic [2:0] S_STREAM  = 3'd2;
  localparam logic [2:0] S_FLUSH   = 3'd3;
  localparam logic [2:0] S_ROW_END = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic signed [FW-1:0] F21  = FW'(21);
  localparam logic signed [FW-1:0] F52  = FW'(52);
  localparam logic signed [FW-1:0] F159 = FW'(159);
  localparam logic signed [FW-1:0] F128 = FW'(128);
  localparam logic signed [PW-1:0] K_Y  = PW'(76284);
  localparam logic signed [PW-1:0] K_RV = PW'(104595);
  localparam logic signed [PW-1:0] K_GU = PW'(25624);
  localparam logic signed [PW-1:0] K_GV = PW'(53281);
  localparam logic signed [PW-1:0] K_BU = PW'(132251);
  localparam logic signed [PW-1:0] Y_OFF = PW'(16 << (DATA_W - 8));
  localparam logic signed [PW-1:0] C_OFF = PW'(1 << (DATA_W - 1));
  localparam logic signed [PW-1:0] MAXV  = PW'((1 << DATA_W) - 1);

  function automatic logic [DATA_W-1:0] clip(input logic signed [PW-1:0] x);
    logic [DATA_W-1:0] r;
    if (x[PW-1]) r = '0;
    else if (x > MAXV) r = MAXV[DATA_W-1:0];
    else r = x[DATA_W-1:0];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] fir6(input logic [DATA_W-1:0] a, b, c, d, e, f);
    logic signed [FW-1:0] acc;
    acc = F21 * $signed(FW'(a)) - F52 * $signed(FW'(b)) + F159 * $signed(FW'(c))
        + F159 * $signed(FW'(d)) - F52 * $signed(FW'(e)) + F21 * $signed(FW'(f)) + F128;
    return clip(PW'(acc >>> 8));
  endfunction

  function automatic logic [3*DATA_W-1:0] csc(input logic [DATA_W-1:0] yi, ui, vi);
    logic signed [PW-1:0] y, u, v;
    y = $signed(PW'(yi)) - Y_OFF;
    u = $signed(PW'(ui)) - C_OFF;
    v = $signed(PW'(vi)) - C_OFF;
    return {clip((K_Y * y + K_RV * v) >>> 16),
            clip((K_Y * y - K_GU * u - K_GV * v) >>> 16),
            clip((K_Y * y + K_BU * u) >>> 16)};
  endfunction

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [RW-1:0]       row_q, row_d;
  logic                mode_q, mode_d;
  logic [DATA_W-1:0]   u_win_q [0:5];
  logic [DATA_W-1:0]   u_win_d [0:5];
  logic [DATA_W-1:0]   v_win_q [0:5];
  logic [DATA_W-1:0]   v_win_d [0:5];
  logic [4*DATA_W-1:0] dly_q [0:3];
  logic [4*DATA_W-1:0] dly_d [0:3];
  logic                win_vld_q, win_vld_d, win_eol_q, win_eol_d;
  logic [2*DATA_W-1:0] s1_y_q, s1_y_d;
  logic [DATA_W-1:0]   s1_ue_q, s1_ue_d, s1_ve_q, s1_ve_d, s1_uo_q, s1_uo_d, s1_vo_q, s1_vo_d;
  logic                s1_vld_q, s1_vld_d, s1_eol_q, s1_eol_d;
  logic [6*DATA_W-1:0] m_data_q, m_data_d;
  logic                m_valid_q, m_valid_d, m_eol_q, m_eol_d, done_q, done_d;

  logic                adv, accept, flush_step, step, fill;
  logic [DATA_W-1:0]   in_u, in_v;
  logic [4*DATA_W-1:0] in_dly;

  // The whole pipeline moves together whenever the output register can take a new value.
  assign adv        = !m_valid_q || m_ready;
  assign s_ready    = ((state_q == S_PRIME) || (state_q == S_STREAM)) && adv;
  assign accept     = s_valid && s_ready;
  assign flush_step = (state_q == S_FLUSH) && adv;
  assign step       = accept || flush_step;
  assign fill       = accept && (state_q == S_PRIME) && (cnt_q == '0);
  assign in_u       = s_data[4*DATA_W-1:3*DATA_W];
  assign in_v       = s_data[3*DATA_W-1:2*DATA_W];
  assign in_dly     = {s_data[6*DATA_W-1:4*DATA_W], s_data[2*DATA_W-1:0]};

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_eol   = m_eol_q;
  assign done    = done_q;

  // Next-state logic: sequencer, chroma window / luma delay, and the two pipeline stages.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    win_vld_d = adv ? 1'b0 : win_vld_q;
    win_eol_d = adv ? 1'b0 : win_eol_q;
    // First pair of a row fills the window, so index clamping at the row start is implicit.
    for (int i = 0; i < 5; i++) begin
      u_win_d[i] = !step ? u_win_q[i] : (fill ? in_u : u_win_q[i+1]);
      v_win_d[i] = !step ? v_win_q[i] : (fill ? in_v : v_win_q[i+1]);
    end
    u_win_d[5] = accept ? in_u : u_win_q[5];
    v_win_d[5] = accept ? in_v : v_win_q[5];
    for (int i = 0; i < 3; i++) dly_d[i] = step ? dly_q[i+1] : dly_q[i];
    dly_d[3] = accept ? in_dly : dly_q[3];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PRIME;
          mode_d  = mode_444;
          cnt_d   = '0;
          row_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRIME: begin
        if (accept) begin
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_q == CW'(2)) ? S_STREAM : S_PRIME;
        end else begin
          state_d = S_PRIME;
        end
      end
      S_STREAM: begin
        if (accept) begin
          win_vld_d = 1'b1;
          if (cnt_q == CW'(ROW_PAIRS - 1)) begin
            state_d = S_FLUSH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = S_STREAM;
        end
      end
      S_FLUSH: begin
        if (flush_step) begin
          win_vld_d = 1'b1;
          if (cnt_q == CW'(2)) begin
            win_eol_d = 1'b1;
            state_d   = S_ROW_END;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_ROW_END: begin
        if (row_q == RW'(ROWS - 1)) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + RW'(1);
          state_d = S_PRIME;
        end
      end
      S_DONE: begin
        if (!win_vld_q && !s1_vld_q && adv) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    s1_vld_d  = adv ? win_vld_q : s1_vld_q;
    s1_eol_d  = adv ? win_eol_q : s1_eol_q;
    s1_y_d    = adv ? dly_q[0][4*DATA_W-1:2*DATA_W] : s1_y_q;
    s1_ue_d   = adv ? u_win_q[2] : s1_ue_q;
    s1_ve_d   = adv ? v_win_q[2] : s1_ve_q;
    s1_uo_d   = !adv ? s1_uo_q : (mode_q ? dly_q[0][2*DATA_W-1:DATA_W] :
                fir6(u_win_q[0], u_win_q[1], u_win_q[2], u_win_q[3], u_win_q[4], u_win_q[5]));
    s1_vo_d   = !adv ? s1_vo_q : (mode_q ? dly_q[0][DATA_W-1:0] :
                fir6(v_win_q[0], v_win_q[1], v_win_q[2], v_win_q[3], v_win_q[4], v_win_q[5]));
    m_valid_d = adv ? s1_vld_q : m_valid_q;
    m_eol_d   = adv ? s1_eol_q : m_eol_q;
    m_data_d  = (adv && s1_vld_q) ?
                {csc(s1_y_q[2*DATA_W-1:DATA_W], s1_ue_q, s1_ve_q),
                 csc(s1_y_q[DATA_W-1:0], s1_uo_q, s1_vo_q)} : m_data_q;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      row_q     <= '0;
      mode_q    <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        u_win_q[i] <= '0;
        v_win_q[i] <= '0;
      end
      for (int i = 0; i < 4; i++) dly_q[i] <= '0;
      win_vld_q <= 1'b0;
      win_eol_q <= 1'b0;
      s1_y_q    <= '0;
      s1_ue_q   <= '0;
      s1_ve_q   <= '0;
      s1_uo_q   <= '0;
      s1_vo_q   <= '0;
      s1_vld_q  <= 1'b0;
      s1_eol_q  <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_eol_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      mode_q    <= mode_d;
      for (int i = 0; i < 6; i++) begin
        u_win_q[i] <= u_win_d[i];
        v_win_q[i] <= v_win_d[i];
      end
      for (int i = 0; i < 4; i++) dly_q[i] <= dly_d[i];
      win_vld_q <= win_vld_d;
      win_eol_q <= win_eol_d;
      s1_y_q    <= s1_y_d;
      s1_ue_q   <= s1_ue_d;
      s1_ve_q   <= s1_ve_d;
      s1_uo_q   <= s1_uo_d;
      s1_vo_q   <= s1_vo_d;
      s1_vld_q  <= s1_vld_d;
      s1_eol_q  <= s1_eol_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_eol_q   <= m_eol_d;
      done_q    <= done_d;
    end
  end
endmodule
